// File: rtl/cella_pkg.sv
// Shared widths and FSM state type for the bit-serial shift accumulator.
package cella_pkg;
  localparam int SUM_W   = 12;
  localparam int IN_BITS = 8;
  localparam int ACC_W   = SUM_W + IN_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;
endpackage

// File: rtl/shift_accumulator.sv
// Bit-serial shift-add accumulator: sums LSB-first plane sums from an
// external adder tree, optionally treating the last plane as a sign plane.
module shift_accumulator
  import cella_pkg::*;
#(
  parameter int SUM_W   = cella_pkg::SUM_W,
  parameter int IN_BITS = cella_pkg::IN_BITS,
  parameter int ACC_W   = cella_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy
);

  localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_BITS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sgn_q, sgn_d;

  logic [ACC_W-1:0] term;
  logic             last;

  assign term = ACC_W'(in_sum) << bit_cnt_q;
  assign last = (bit_cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      sgn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      sgn_q     <= sgn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    sgn_d     = sgn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          acc_d     = '0;
          bit_cnt_d = '0;
          sgn_d     = signed_mode;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          // sign plane carries weight -2^(IN_BITS-1)
          if (sgn_q && last) acc_d = acc_q - term;
          else               acc_d = acc_q + term;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last) begin
            state_d   = HOLD;
            bit_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d   = ACCUM;
            acc_d     = '0;
            bit_cnt_d = '0;
            sgn_d     = signed_mode;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = out_valid ? acc_q : '0;
  assign busy      = (state_q != IDLE);

endmodule
